// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture
// Receive side of a time-multiplexed 4-digit seven-segment bus. The block
// registers an/sseg, waits for each digit slot to hold still for SETTLE
// cycles, and decodes the segment pattern back to a hex nibble plus dp bit.
// Once every slot has been captured since the last frame, it pulses
// frame_valid.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   an[3:0]      digit enables, active-low, one-hot-low selects slot 0..3
//   sseg[7:0]    segments, active-low: [7]=dp, [6]=a .. [0]=g
//   digits[15:0] captured nibbles, slot k at [4k+3:4k]
//   dps[3:0]     captured dp per slot, 1 = dp lit
//   slot_ok[3:0] last capture of the slot decoded to a legal hex glyph
//   frame_valid  1-cycle pulse, registered in the same edge as the capture
//                that completes the frame
//   err          1-cycle pulse on entry to an illegal an value, or on a
//                capture whose glyph does not decode
//   state_dbg    current FSM state (0=BLANK, 1=SETTLE, 2=HOLD)
//
// There are no valid/ready handshakes: frame_valid and err are
// unconditional single-cycle strobes that the consumer must sample.
module sseg_scan_capture #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  slot_ok,
  output logic        frame_valid,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] an_q, an_p;
  logic [7:0] sseg_q, sseg_p;
  logic [3:0] seen;

  logic       changed;
  logic       an_changed;
  logic       slot_legal;
  logic [1:0] slot;
  logic       an_illegal;
  logic       capture;
  logic       glyph_ok;
  logic [3:0] glyph_nib;
  logic [3:0] seen_upd;

  // Segment pattern (a..g, active-low) to {legal, nibble}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    case (s)
      7'b0000001: glyph_decode = {1'b1, 4'h0};
      7'b1001111: glyph_decode = {1'b1, 4'h1};
      7'b0010010: glyph_decode = {1'b1, 4'h2};
      7'b0000110: glyph_decode = {1'b1, 4'h3};
      7'b1001100: glyph_decode = {1'b1, 4'h4};
      7'b0100100: glyph_decode = {1'b1, 4'h5};
      7'b0100000: glyph_decode = {1'b1, 4'h6};
      7'b0001111: glyph_decode = {1'b1, 4'h7};
      7'b0000000: glyph_decode = {1'b1, 4'h8};
      7'b0000100: glyph_decode = {1'b1, 4'h9};
      7'b0001000: glyph_decode = {1'b1, 4'hA};
      7'b1100000: glyph_decode = {1'b1, 4'hB};
      7'b0110001: glyph_decode = {1'b1, 4'hC};
      7'b1000010: glyph_decode = {1'b1, 4'hD};
      7'b0110000: glyph_decode = {1'b1, 4'hE};
      7'b0111000: glyph_decode = {1'b1, 4'hF};
      default:    glyph_decode = 5'b0;
    endcase
  endfunction

  // Input stage plus a one-cycle-older copy used for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q   <= 4'hF;
      sseg_q <= 8'hFF;
      an_p   <= 4'hF;
      sseg_p <= 8'hFF;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      an_p   <= an_q;
      sseg_p <= sseg_q;
    end
  end

  always_comb begin
    slot_legal = 1'b1;
    slot       = 2'd0;
    case (an_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot_legal = 1'b0;
    endcase
  end

  assign an_illegal = !slot_legal && (an_q != 4'hF);
  assign an_changed = (an_q != an_p);
  assign changed    = an_changed || (sseg_q != sseg_p);
  assign {glyph_ok, glyph_nib} = glyph_decode(sseg_q[6:0]);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_BLANK;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Any change of the registered bus restarts the settle window and
  // re-evaluates the slot, whatever state the FSM is in.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      S_BLANK: begin
        if (slot_legal) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          cnt_n   = '0;
          state_n = slot_legal ? S_SETTLE : S_BLANK;
        end else if (cnt == CNT_W'(SETTLE - 1)) begin
          capture = 1'b1;
          state_n = S_HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (changed) begin
          cnt_n   = '0;
          state_n = slot_legal ? S_SETTLE : S_BLANK;
        end
      end
      default: begin
        state_n = S_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  assign seen_upd = seen | (4'b0001 << slot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= '0;
      dps         <= '0;
      slot_ok     <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      // Illegal an only flags on the cycle it first appears.
      err         <= (an_illegal && an_changed) || (capture && !glyph_ok);
      if (capture) begin
        dps[slot]     <= ~sseg_q[7];
        slot_ok[slot] <= glyph_ok;
        if (glyph_ok) begin
          digits[{slot, 2'b00} +: 4] <= glyph_nib;
        end
        if (&seen_upd) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
module tb_sseg_scan_capture;

  localparam int SETTLE = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sseg = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  slot_ok;
  logic        frame_valid;
  logic        err;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  sseg_scan_capture #(.SETTLE(SETTLE), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .an          (an),
    .sseg        (sseg),
    .digits      (digits),
    .dps         (dps),
    .slot_ok     (slot_ok),
    .frame_valid (frame_valid),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model ----------------
  // Glyph patterns for 0..F, segments a..g active-low.
  logic [6:0] gtab [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [15:0] e_digits;
  logic [3:0]  e_dps, e_ok, m_seen;
  logic        e_fv, e_err;
  logic [3:0]  m_an_prev;
  logic [7:0]  m_ss_prev;
  int          m_run;
  logic        pend_cap, pend_ill;
  int          pend_slot;
  logic [7:0]  pend_ss;

  int n_vec  = 0;
  int n_miss = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  // -1 = blank, -2 = illegal, else slot number of the single low bit.
  function automatic int slot_of(input logic [3:0] a);
    if (a == 4'hF) return -1;
    if ($countones(~a) != 1) return -2;
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return -2;
  endfunction

  function automatic int glyph_idx(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (gtab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    e_digits = '0; e_dps = '0; e_ok = '0; m_seen = '0;
    e_fv = 1'b0; e_err = 1'b0;
    m_an_prev = 4'hF; m_ss_prev = 8'hFF; m_run = 1;
    pend_cap = 1'b0; pend_ill = 1'b0; pend_slot = 0; pend_ss = 8'hFF;
  endtask

  // Called once per clock edge. A bus value becomes a capture once it has
  // been sampled SETTLE+1 times in a row (arrival plus SETTLE stable cycles);
  // the result appears one edge after that sample.
  task automatic model_edge();
    int g;
    e_fv  = 1'b0;
    e_err = pend_ill;
    if (pend_cap) begin
      e_dps[pend_slot] = ~pend_ss[7];
      g = glyph_idx(pend_ss[6:0]);
      if (g >= 0) begin
        e_digits[pend_slot*4 +: 4] = g[3:0];
        e_ok[pend_slot] = 1'b1;
      end else begin
        e_ok[pend_slot] = 1'b0;
        e_err = 1'b1;
      end
      m_seen[pend_slot] = 1'b1;
      if (m_seen == 4'hF) begin
        e_fv = 1'b1;
        m_seen = 4'h0;
      end
    end
    if (an == m_an_prev && sseg == m_ss_prev) m_run++;
    else m_run = 1;
    pend_ill  = (an != m_an_prev) && (slot_of(an) == -2);
    pend_cap  = (m_run == SETTLE + 1) && (slot_of(an) >= 0);
    pend_slot = slot_of(an) >= 0 ? slot_of(an) : 0;
    pend_ss   = sseg;
    m_an_prev = an;
    m_ss_prev = sseg;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("digits", 32'(digits), 32'(e_digits));
    chk("dps", 32'(dps), 32'(e_dps));
    chk("slot_ok", 32'(slot_ok), 32'(e_ok));
    chk("frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("err", 32'(err), 32'(e_err));
    if (frame_valid === 1'b1) fv_cnt++;
    if (err === 1'b1) err_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] a, input logic [7:0] s);
    an = a;
    sseg = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] a;
    a = 4'hF;
    a[k] = 1'b0;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int fv0, err0, len, kind, k;
    logic [3:0] ra;
    logic [7:0] rs;

    model_reset();
    #2;
    do_reset();

    // Static slot 0, glyph 2, dp off.
    err0 = err_cnt;
    hold(4'b1110, {1'b1, gtab[2]}, 10);
    chk("static_digit", 32'(digits[3:0]), 32'h2);
    chk("static_err", 32'(err_cnt - err0), 32'd0);

    // Full frame 1,2,3,4 with dp on slot 2.
    fv0 = fv_cnt;
    hold(an_of(0), {1'b1, gtab[1]}, 8);
    hold(an_of(1), {1'b1, gtab[2]}, 8);
    hold(an_of(2), {1'b0, gtab[3]}, 8);
    hold(an_of(3), {1'b1, gtab[4]}, 8);
    chk("frame_pulses", 32'(fv_cnt - fv0), 32'd1);
    chk("frame_digits", 32'(digits), 32'h4321);
    chk("frame_dps", 32'(dps), 32'b0100);
    chk("frame_ok", 32'(slot_ok), 32'hF);

    // Glitch inside settle window, then a 1-cycle blank gap.
    hold(an_of(1), {1'b1, gtab[5]}, 3);
    hold(an_of(1), {1'b1, gtab[6]}, 6);
    hold(an_of(2), {1'b1, gtab[7]}, 2);
    step(4'hF, 8'hFF);
    hold(an_of(2), {1'b1, gtab[7]}, 3);
    hold(an_of(2), {1'b1, gtab[9]}, 6);

    // Illegal an held: exactly one err pulse.
    err0 = err_cnt;
    hold(4'b1100, {1'b1, gtab[8]}, 5);
    hold(4'hF, 8'hFF, 2);
    chk("illegal_err_pulses", 32'(err_cnt - err0), 32'd1);

    // Undecodable glyph on slot 1.
    hold(an_of(1), 8'hFF, 7);
    chk("bad_glyph_ok", 32'(slot_ok[1]), 32'd0);
    chk("bad_glyph_digit", 32'(digits[7:4]), 32'h6);

    // Order/repeat 3,3,0,2,1 from a clean frame.
    do_reset();
    fv0 = fv_cnt;
    hold(an_of(3), {1'b1, gtab[10]}, 6);
    step(4'hF, 8'hFF);
    hold(an_of(3), {1'b1, gtab[11]}, 6);
    hold(an_of(0), {1'b1, gtab[12]}, 6);
    hold(an_of(2), {1'b1, gtab[13]}, 6);
    chk("order_no_early_frame", 32'(fv_cnt - fv0), 32'd0);
    hold(an_of(1), {1'b1, gtab[14]}, 6);
    chk("order_frame", 32'(fv_cnt - fv0), 32'd1);
    hold(an_of(1), {1'b0, gtab[15]}, 6);
    chk("order_next_needs_all", 32'(fv_cnt - fv0), 32'd1);

    // Reset after three slots, then slot 3 alone.
    hold(an_of(0), {1'b1, gtab[1]}, 6);
    hold(an_of(1), {1'b1, gtab[2]}, 6);
    hold(an_of(2), {1'b1, gtab[3]}, 6);
    do_reset();
    fv0 = fv_cnt;
    hold(an_of(3), {1'b1, gtab[4]}, 8);
    chk("reset_discards_partial", 32'(fv_cnt - fv0), 32'd0);

    // Randomized segments.
    for (int seg = 0; seg < 300; seg++) begin
      kind = $urandom_range(0, 99);
      len  = $urandom_range(1, 8);
      rs   = 8'($urandom_range(0, 255));
      if (kind < 72) begin
        k  = $urandom_range(0, 3);
        ra = an_of(k);
        rs = {1'($urandom_range(0, 1)), gtab[$urandom_range(0, 15)]};
      end else if (kind < 80) begin
        k  = $urandom_range(0, 3);
        ra = an_of(k);
      end else if (kind < 90) begin
        ra = 4'hF;
      end else begin
        ra = 4'($urandom_range(0, 15));
        while ($countones(~ra) < 2) ra = 4'($urandom_range(0, 15));
      end
      if (kind == 99) do_reset();
      hold(ra, rs, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
